// File: rtl/mat_square_seq.sv
// Sequential fixed-point A*A: one signed 33x33 multiplier and a 68-bit accumulator
// walk 27 MAC steps (3 per element) and write each element with optional saturation.
module mat_square_seq #(
  parameter int FRAC_BITS = 6,
  parameter bit SATURATE  = 1
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               i_en,
  input  logic               i_start,
  input  logic signed [32:0] i_mat00, i_mat01, i_mat02,
  input  logic signed [32:0] i_mat10, i_mat11, i_mat12,
  input  logic signed [32:0] i_mat20, i_mat21, i_mat22,
  output logic signed [32:0] o_mat00, o_mat01, o_mat02,
  output logic signed [32:0] o_mat10, o_mat11, o_mat12,
  output logic signed [32:0] o_mat20, o_mat21, o_mat22,
  output logic               o_busy,
  output logic               o_Dval
);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam logic signed [67:0] MAXV = 68'sd4294967295;
  localparam logic signed [67:0] MINV = -68'sd4294967296;

  state_t state, state_nxt;
  logic [2:0][2:0][32:0] a, res;
  logic [1:0]            i, j, k;
  logic signed [67:0]    acc, sum, shifted;
  logic signed [65:0]    prod;
  logic [32:0]           res_val;
  logic                  last;

  assign prod    = $signed(a[i][k]) * $signed(a[k][j]);
  assign sum     = acc + prod;
  assign shifted = sum >>> FRAC_BITS;
  assign last    = (i == 2'd2) && (j == 2'd2) && (k == 2'd2);

  always_comb begin
    res_val = shifted[32:0];
    if (SATURATE) begin
      if (shifted > MAXV)      res_val = MAXV[32:0];
      else if (shifted < MINV) res_val = MINV[32:0];
    end
  end

  always_comb begin
    state_nxt = state;
    if (i_en) begin
      case (state)
        IDLE, DONE: if (i_start) state_nxt = MAC;
        MAC:        if (last)    state_nxt = DONE;
        default:                 state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      a      <= '0;
      res    <= '0;
      acc    <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      o_busy <= 1'b0;
      o_Dval <= 1'b0;
    end else if (i_en) begin
      case (state)
        IDLE, DONE: if (i_start) begin
          a[0][0] <= i_mat00; a[0][1] <= i_mat01; a[0][2] <= i_mat02;
          a[1][0] <= i_mat10; a[1][1] <= i_mat11; a[1][2] <= i_mat12;
          a[2][0] <= i_mat20; a[2][1] <= i_mat21; a[2][2] <= i_mat22;
          acc    <= '0;
          i      <= '0;
          j      <= '0;
          k      <= '0;
          o_busy <= 1'b1;
          o_Dval <= 1'b0;
        end
        MAC: if (k == 2'd2) begin
          // third product of the dot product goes straight to the result
          res[i][j] <= res_val;
          acc       <= '0;
          k         <= '0;
          if (j == 2'd2) begin
            j <= '0;
            i <= (i == 2'd2) ? 2'd0 : i + 2'd1;
          end else begin
            j <= j + 2'd1;
          end
          if (last) begin
            o_busy <= 1'b0;
            o_Dval <= 1'b1;
          end
        end else begin
          acc <= sum;
          k   <= k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_mat00 = res[0][0]; assign o_mat01 = res[0][1]; assign o_mat02 = res[0][2];
  assign o_mat10 = res[1][0]; assign o_mat11 = res[1][1]; assign o_mat12 = res[1][2];
  assign o_mat20 = res[2][0]; assign o_mat21 = res[2][1]; assign o_mat22 = res[2][2];
endmodule

// File: tb/tb_mat_square_seq.sv
// Randomized bench for mat_square_seq: saturating and wrapping instances share inputs
// and are compared against a plain matrix-multiply reference.
module tb_mat_square_seq;
  localparam int FB = 6;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0;
  logic signed [32:0] m [9];
  logic signed [32:0] os [9];
  logic signed [32:0] ow [9];
  logic signed [32:0] exp_s [9];
  logic signed [32:0] exp_w [9];
  logic busy_s, dval_s, busy_w, dval_w;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mat_square_seq #(.FRAC_BITS(FB), .SATURATE(1)) dut (
    .iclk(clk), .ireset(rst_n), .i_en(en), .i_start(start),
    .i_mat00(m[0]), .i_mat01(m[1]), .i_mat02(m[2]),
    .i_mat10(m[3]), .i_mat11(m[4]), .i_mat12(m[5]),
    .i_mat20(m[6]), .i_mat21(m[7]), .i_mat22(m[8]),
    .o_mat00(os[0]), .o_mat01(os[1]), .o_mat02(os[2]),
    .o_mat10(os[3]), .o_mat11(os[4]), .o_mat12(os[5]),
    .o_mat20(os[6]), .o_mat21(os[7]), .o_mat22(os[8]),
    .o_busy(busy_s), .o_Dval(dval_s));

  mat_square_seq #(.FRAC_BITS(FB), .SATURATE(0)) dut_w (
    .iclk(clk), .ireset(rst_n), .i_en(en), .i_start(start),
    .i_mat00(m[0]), .i_mat01(m[1]), .i_mat02(m[2]),
    .i_mat10(m[3]), .i_mat11(m[4]), .i_mat12(m[5]),
    .i_mat20(m[6]), .i_mat21(m[7]), .i_mat22(m[8]),
    .o_mat00(ow[0]), .o_mat01(ow[1]), .o_mat02(ow[2]),
    .o_mat10(ow[3]), .o_mat11(ow[4]), .o_mat12(ow[5]),
    .o_mat20(ow[6]), .o_mat21(ow[7]), .o_mat22(ow[8]),
    .o_busy(busy_w), .o_Dval(dval_w));

  // Reference: exact matrix product, floor shift, then clamp or keep low 33 bits.
  function automatic void model();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        logic signed [67:0] s;
        s = '0;
        for (int t = 0; t < 3; t++) s = s + 68'(m[r*3+t]) * 68'(m[t*3+c]);
        s = s >>> FB;
        exp_w[r*3+c] = s[32:0];
        if (s > 68'sd4294967295)       exp_s[r*3+c] = 33'sh0FFFFFFFF;
        else if (s < -68'sd4294967296) exp_s[r*3+c] = 33'sh100000000;
        else                           exp_s[r*3+c] = s[32:0];
      end
  endfunction

  task automatic start_op();
    @(negedge clk);
    en = 1'b1; start = 1'b1;
    model();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dval(output int n);
    n = 0;
    while (!dval_s && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic set_rand(input int big);
    for (int e = 0; e < 9; e++) begin
      if (big != 0) m[e] = 33'({$urandom, $urandom});
      else          m[e] = 33'($signed(17'($urandom)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; start = 1'b0;
    for (int e = 0; e < 9; e++) m[e] = 33'sd77;
    #1;
    total++; if (busy_s !== 1'b0 || dval_s !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b dval=%b want 0 0", busy_s, dval_s); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== 33'sd0) begin bad++; $display("FAIL reset_mat e%0d got %0d want 0", e, os[e]); end
    end
    @(negedge clk); rst_n = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL start_gated_by_en busy=%b want 0", busy_s); end
  endtask

  task automatic test_patterns();
    int n;
    for (int p = 0; p < 5; p++) begin
      for (int e = 0; e < 9; e++) begin
        case (p)
          0: m[e] = (e % 4 == 0) ? 33'sd64 : 33'sd0;
          1: m[e] = -33'sd64;
          2: m[e] = (e % 4 == 0) ? 33'sd128 : 33'sd0;
          3: m[e] = (e % 4 == 0) ? 33'sd1073741824 : 33'sd0;
          default: m[e] = (e % 4 == 0) ? -33'sd1 : 33'sd0;
        endcase
      end
      start_op();
      wait_dval(n);
      total++; if (n != 27) begin bad++; $display("FAIL pat%0d_latency got %0d want 27", p, n); end
      for (int e = 0; e < 9; e++) begin
        total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL pat%0d_sat e%0d got %0d want %0d", p, e, os[e], exp_s[e]); end
        total++; if (ow[e] !== exp_w[e]) begin bad++; $display("FAIL pat%0d_wrap e%0d got %0d want %0d", p, e, ow[e], exp_w[e]); end
      end
    end
    // spot-check the reference itself on the spec's fixed points
    total++; if (exp_s[0] !== 33'sd0) begin bad++; $display("FAIL trunc_neg1 got %0d want 0", exp_s[0]); end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 10; t++) begin
      set_rand(t % 3 == 2);
      start_op();
      wait_dval(n);
      total++; if (n != 27 || dval_w !== 1'b1) begin bad++; $display("FAIL rnd%0d_latency got %0d dval_w=%b want 27 1", t, n, dval_w); end
      for (int e = 0; e < 9; e++) begin
        total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL rnd%0d_sat e%0d got %0d want %0d", t, e, os[e], exp_s[e]); end
        total++; if (ow[e] !== exp_w[e]) begin bad++; $display("FAIL rnd%0d_wrap e%0d got %0d want %0d", t, e, ow[e], exp_w[e]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    repeat (4) @(negedge clk);
    total++; if (dval_s !== 1'b1 || busy_s !== 1'b0) begin bad++; $display("FAIL done_hold dval=%b busy=%b want 1 0", dval_s, busy_s); end
    set_rand(0);
    start_op();
    total++; if (dval_s !== 1'b0 || busy_s !== 1'b1) begin bad++; $display("FAIL restart_from_done dval=%b busy=%b want 0 1", dval_s, busy_s); end
    wait_dval(n);
    total++; if (n != 27) begin bad++; $display("FAIL b2b_latency got %0d want 27", n); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL b2b e%0d got %0d want %0d", e, os[e], exp_s[e]); end
    end
  endtask

  task automatic test_restart_ignore();
    int n;
    set_rand(0);
    start_op();
    repeat (9) @(negedge clk);
    set_rand(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dval(n);
    total++; if (n + 10 != 27) begin bad++; $display("FAIL ignore_latency got %0d want 27", n + 10); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL ignore e%0d got %0d want %0d", e, os[e], exp_s[e]); end
    end
  endtask

  task automatic test_en_gaps();
    int n;
    set_rand(0);
    start_op();
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_dval(n);
    total++; if (n + 10 != 32) begin bad++; $display("FAIL en_gap_latency got %0d want 32", n + 10); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL en_gap e%0d got %0d want %0d", e, os[e], exp_s[e]); end
    end
  endtask

  task automatic test_mid_reset();
    int n, seen;
    set_rand(0);
    start_op();
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy_s !== 1'b0 || dval_s !== 1'b0) begin bad++; $display("FAIL midrst_flags busy=%b dval=%b want 0 0", busy_s, dval_s); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== 33'sd0) begin bad++; $display("FAIL midrst_mat e%0d got %0d want 0", e, os[e]); end
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dval_s || busy_s) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_dval active_cycles=%0d want 0", seen); end
    set_rand(1);
    start_op();
    wait_dval(n);
    total++; if (n != 27) begin bad++; $display("FAIL midrst_latency got %0d want 27", n); end
    for (int e = 0; e < 9; e++) begin
      total++; if (os[e] !== exp_s[e]) begin bad++; $display("FAIL midrst_res e%0d got %0d want %0d", e, os[e], exp_s[e]); end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_restart_ignore();
    test_en_gaps();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mat_square_seq.md
MAT_SQUARE_SEQ -- requirements
Module: mat_square_seq

Interface
REQ-001 Parameter FRAC_BITS, default 6: fractional bits of the fixed-point format; 1.0 = 64 at the default.
REQ-002 Parameter SATURATE, default 1: 1 = clamp results to the 33-bit signed range; 0 = keep the low 33 bits (wrap).
REQ-003 Port iclk, input, 1: clock; all state changes on the rising edge.
REQ-004 Port ireset, input, 1: reset, asynchronous, active-low.
REQ-005 Port i_en, input, 1: clock enable; when low, all registers hold their values.
REQ-006 Port i_start, input, 1: start request, sampled while i_en=1.
REQ-007 Ports i_mat00..i_mat22, input, 33 each, signed: operand matrix A, row-major.
REQ-008 Ports o_mat00..o_mat22, output, 33 each, signed, registered: result matrix A*A.
REQ-009 Port o_busy, output, 1: high while a computation is in progress.
REQ-010 Port o_Dval, output, 1: result valid; level signal.

Function
REQ-011 The block shall compute A*A (the inverse check of the square-root engine) using one signed 33x33 multiplier and a 68-bit signed accumulator.
REQ-012 FSM states: IDLE, MAC, DONE; transitions occur only on edges where i_en=1.
REQ-013 IDLE or DONE with i_start=1: latch all nine i_mat into internal A registers, clear the accumulator, set i=j=k=0, o_busy<=1, o_Dval<=0, go to MAC.
REQ-014 MAC, each enabled cycle: acc <= acc + A[i][k]*A[k][j]; k increments 0..2.
REQ-015 On the k=2 cycle: write (acc + product) >>> FRAC_BITS to o_mat[i][j] (arithmetic shift, truncation toward minus infinity), clear acc, k<=0, advance j, then i on j wrap.
REQ-016 Element order: 00,01,02,10,...,22; exactly 27 MAC cycles per operation.
REQ-017 After writing element 22: go to DONE with o_Dval<=1 and o_busy<=0 on the same edge.
REQ-018 Latency: start accepted at enabled edge N -> o_Dval high after edge N+27, with i_en held high.
REQ-019 Each i_en=0 cycle extends the latency by exactly one cycle; no MAC step is lost or duplicated.
REQ-020 i_start while in MAC shall be ignored; the in-flight operation and the latched A are unaffected.
REQ-021 i_mat changes after the start edge shall not affect the result.
REQ-022 o_Dval stays high in DONE until the next accepted i_start, which clears it on the accepting edge.
REQ-023 o_mat elements are written progressively during MAC and are defined only while o_Dval=1.
REQ-024 SATURATE=1: a shifted sum above 4294967295 yields 4294967295; one below -4294967296 yields -4294967296.
REQ-025 SATURATE=0: the result is bits [32:0] of the shifted sum.

Reset
REQ-026 ireset=0 immediately forces: state IDLE; i, j, k, acc and A cleared; o_mat* = 0; o_busy = 0; o_Dval = 0.
REQ-027 Reset asserted mid-operation aborts the operation; after release, no o_Dval occurs without a new i_start.

Verification
REQ-028 A = identity (diagonal 64, others 0), pulse i_start -> after 27 cycles o_Dval=1, o_mat = diagonal 64, others 0.
REQ-029 All nine entries -64 -> every o_mat element = 192; diagonal 128 only -> diagonal 256, others 0.
REQ-030 Diagonal 1073741824, SATURATE=1 -> diagonal 4294967295, others 0; diagonal -1 -> diagonal 0 (truncation).
REQ-031 i_start re-pulsed at MAC cycle 10 with a different i_mat -> first result unchanged, o_Dval still at N+27; i_en low 5 cycles during MAC -> o_Dval at N+32.
REQ-032 ireset pulsed at MAC cycle 15 -> all outputs 0 immediately; no o_Dval for 40 cycles; a new start then completes correctly.
